mult_ctrl: RTL

//  Control FSM for the shift-add signed multiplier datapath. It sequences the
//  8-bit shift registers: A (accumulator) with its sign flop X, and B
//  (multiplier), plus the 9-bit add/sub unit.
//  It emits load, clear, shift and add/sub strobes for N add-shift iterations,

---
 rtl/mult_ctrl_if.sv | 23 ++
 rtl/mult_ctrl.sv | 48 ++++
 2 files changed

// File: rtl/mult_ctrl_if.sv
// mult_ctrl_if: switch, multiplier-bit and strobe bundle between mult_ctrl and the datapath
interface mult_ctrl_if #(parameter int N = 8);
  localparam int CW = $clog2(N);
  logic run;
  logic clear_a_load_b;
  logic m;
  logic clear_a;
  logic ld_b;
  logic ld_a;
  logic sub;
  logic shift_en;
  logic busy;
  logic done;
  logic [CW-1:0] iter;
  modport master (
    output run, clear_a_load_b, m,
    input  clear_a, ld_b, ld_a, sub, shift_en, busy, done, iter
  );
  modport slave (
    input  run, clear_a_load_b, m,
    output clear_a, ld_b, ld_a, sub, shift_en, busy, done, iter
  );
endinterface

// File: rtl/mult_ctrl.sv
// mult_ctrl: shift-add signed multiplier control FSM, N add/shift iterations then hold until run drops
module mult_ctrl #(parameter int N = 8) (
  input logic clk,
  input logic reset_n,
  mult_ctrl_if.slave bus
);
  localparam int CW = $clog2(N);
  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic last, load_req;
  assign last = cnt == CW'(N - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = bus.run ? CLEAR : IDLE;
      CLEAR:   state_nx = ADD;
      ADD:     state_nx = SHIFT;
      SHIFT:   state_nx = last ? DONE : ADD;
      DONE:    state_nx = bus.run ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
    cnt_nx = state == CLEAR ? '0 :
             (state == SHIFT && !last) ? cnt + CW'(1) :
             (state == DONE && !bus.run) ? '0 : cnt;
  end
  // switch load is Mealy in IDLE, suppressed by run and by an asserted reset
  assign load_req = state == IDLE && reset_n && !bus.run && bus.clear_a_load_b;
  always_comb begin
    bus.clear_a  = state == CLEAR || load_req;
    bus.ld_b     = load_req;
    bus.ld_a     = state == ADD && bus.m;
    bus.sub      = state == ADD && bus.m && last;
    bus.shift_en = state == SHIFT;
    bus.busy     = state == CLEAR || state == ADD || state == SHIFT;
    bus.done     = state == DONE;
    bus.iter     = cnt;
  end
endmodule
